// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: LSB-first modular exponentiation sequencer around a shared Montgomery multiplier.
// Define RSA_EARLY_EXIT_EN to stop as soon as the remaining exponent bits are all zero.
module rsa_exp_ctrl #(
    parameter int KEY_BITS = 256,
    parameter int PRE_BITS = 256
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [255:0] i_x,
    input  logic [255:0] i_d,
    input  logic [255:0] i_n,
    output logic [255:0] o_y,
    output logic         o_finished,
    output logic         o_busy,
    output logic         mm_start,
    output logic [255:0] mm_a,
    output logic [255:0] mm_b,
    output logic [256:0] mm_n,
    input  logic [255:0] mm_result,
    input  logic         mm_finished
);
    localparam int BW = $clog2(KEY_BITS + 1);
    localparam int PW = $clog2(PRE_BITS + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(KEY_BITS);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_BITS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_BIT,
        S_MUL_WAIT,
        S_GAP_M,
        S_SQR,
        S_SQR_WAIT,
        S_GAP_S,
        S_DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [255:0]  m;
    logic [255:0]  t;
    logic [255:0]  d_sh;
    logic [255:0]  n_r;
    logic [BW-1:0] bit_cnt;
    logic [PW-1:0] pre_cnt;
    logic [256:0]  t2;
    logic [255:0]  t_pre;
    logic          last_bit;
    logic          issue_mul;
    logic          issue_sqr;

    // One doubling step of t = x * 2^PRE_BITS mod n
    always_comb begin
        t2 = {t, 1'b0};
        t_pre = t2[255:0];
        if (t2 >= {1'b0, n_r})
            t_pre = 256'(t2 - {1'b0, n_r});
    end

`ifdef RSA_EARLY_EXIT_EN
    assign last_bit = (bit_cnt == BIT_LAST) || (d_sh == '0);
`else
    assign last_bit = (bit_cnt == BIT_LAST);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        issue_mul = 1'b0;
        issue_sqr = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_start)
                    state_n = S_PRE;
            end
            S_PRE: begin
                if (pre_cnt == PRE_LAST)
                    state_n = S_BIT;
            end
            S_BIT: begin
                if (d_sh[0]) begin
                    issue_mul = 1'b1;
                    state_n = S_MUL_WAIT;
                end else begin
                    state_n = S_SQR;
                end
            end
            S_MUL_WAIT: begin
                if (mm_finished)
                    state_n = S_GAP_M;
            end
            S_GAP_M: state_n = S_SQR;
            S_SQR: begin
                issue_sqr = 1'b1;
                state_n = S_SQR_WAIT;
            end
            S_SQR_WAIT: begin
                if (mm_finished)
                    state_n = S_GAP_S;
            end
            S_GAP_S: state_n = last_bit ? S_DONE : S_BIT;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign o_busy = (state != S_IDLE);
    assign o_finished = (state == S_DONE);
    assign mm_n = {1'b0, n_r};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m <= '0;
            t <= '0;
            d_sh <= '0;
            n_r <= '0;
            bit_cnt <= '0;
            pre_cnt <= '0;
            o_y <= '0;
            mm_start <= 1'b0;
            mm_a <= '0;
            mm_b <= '0;
        end else begin
            mm_start <= issue_mul | issue_sqr;
            if (state == S_IDLE && i_start) begin
                n_r <= i_n;
                d_sh <= i_d;
                t <= i_x;
                m <= 256'd1;
                bit_cnt <= '0;
                pre_cnt <= '0;
            end
            if (state == S_PRE) begin
                t <= t_pre;
                pre_cnt <= pre_cnt + PW'(1);
            end
            // Operands stay registered until the next issue
            if (issue_mul) begin
                mm_a <= m;
                mm_b <= t;
            end
            if (issue_sqr) begin
                mm_a <= t;
                mm_b <= t;
            end
            if (state == S_MUL_WAIT && mm_finished)
                m <= mm_result;
            if (state == S_SQR_WAIT && mm_finished) begin
                t <= mm_result;
                d_sh <= d_sh >> 1;
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (state == S_GAP_S && last_bit)
                o_y <= m;
        end
    end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// tb_rsa_exp_ctrl: randomized scoreboard bench with a behavioural Montgomery multiplier.
// Expected results come from plain modular arithmetic on wide vectors.
module tb_rsa_exp_ctrl;
    localparam int KEY_BITS = 256;
    localparam int PRE_BITS = 256;
    localparam int BOUND = 30000;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [255:0] i_x;
    logic [255:0] i_d;
    logic [255:0] i_n;
    logic [255:0] o_y;
    logic         o_finished;
    logic         o_busy;
    logic         mm_start;
    logic [255:0] mm_a;
    logic [255:0] mm_b;
    logic [256:0] mm_n;
    logic [255:0] mm_result;
    logic         mm_finished;

    rsa_exp_ctrl #(
        .KEY_BITS(KEY_BITS),
        .PRE_BITS(PRE_BITS)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(i_start),
        .i_x(i_x),
        .i_d(i_d),
        .i_n(i_n),
        .o_y(o_y),
        .o_finished(o_finished),
        .o_busy(o_busy),
        .mm_start(mm_start),
        .mm_a(mm_a),
        .mm_b(mm_b),
        .mm_n(mm_n),
        .mm_result(mm_result),
        .mm_finished(mm_finished)
    );

    typedef struct {
        logic [255:0] y;
        int           starts;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           starts_total = 0;
    logic [255:0] cur_n = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input bit ok, input string nm,
                                  input logic [256:0] act, input logic [256:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++)
            r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Golden x^d mod n by square-and-multiply on 512-bit products
    function automatic logic [255:0] modexp(input logic [255:0] x,
                                            input logic [255:0] d,
                                            input logic [255:0] n);
        logic [511:0] r;
        logic [511:0] b;
        logic [511:0] nn;
        nn = {256'd0, n};
        r = 512'd1;
        b = {256'd0, x} % nn;
        for (int i = 0; i < KEY_BITS; i++) begin
            if (d[i])
                r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[255:0];
    endfunction

    // Multiplier starts the sequencer should issue for exponent d
    function automatic int exp_starts(input logic [255:0] d);
        int pc;
        int hi;
        pc = 0;
        hi = 0;
        for (int i = 0; i < KEY_BITS; i++) begin
            if (d[i]) begin
                pc++;
                hi = i + 1;
            end
        end
`ifdef RSA_EARLY_EXIT_EN
        return pc + ((hi == 0) ? 1 : hi);
`else
        return pc + KEY_BITS;
`endif
    endfunction

    // Montgomery product a*b*2^-256 mod n
    function automatic logic [255:0] mont(input logic [255:0] a,
                                          input logic [255:0] b,
                                          input logic [255:0] n);
        logic [257:0] u;
        u = '0;
        for (int i = 0; i < PRE_BITS; i++) begin
            if (a[i])
                u = u + {2'b0, b};
            if (u[0])
                u = u + {2'b0, n};
            u = u >> 1;
        end
        if (u >= {2'b0, n})
            u = u - {2'b0, n};
        return u[255:0];
    endfunction

    // Behavioural multiplier plus handshake protocol checks
    initial begin
        bit           pend;
        bit           stable;
        int           cnt;
        int           cyc;
        int           last_st;
        int           last_fin;
        logic [255:0] ca;
        logic [255:0] cb;
        logic [255:0] cn;
        pend = 0;
        stable = 1;
        cnt = 0;
        cyc = 0;
        last_st = -10;
        last_fin = -10;
        ca = '0;
        cb = '0;
        cn = '0;
        mm_finished = 1'b0;
        mm_result = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend = 0;
                mm_finished = 1'b0;
                last_st = -10;
                last_fin = -10;
                continue;
            end
            mm_finished = 1'b0;
            if (pend) begin
                if (mm_a !== ca || mm_b !== cb)
                    stable = 0;
                if (cnt == 0) begin
                    check(stable, "mm_operand_stable", {256'd0, stable}, 257'd1);
                    mm_result = mont(ca, cb, cn);
                    mm_finished = 1'b1;
                    pend = 0;
                    last_fin = cyc;
                end else begin
                    cnt--;
                end
            end
            if (mm_start) begin
                check(!pend && cyc != last_st + 1 && cyc >= last_fin + 2,
                      "mm_start_spacing", 257'(cyc), 257'(last_fin + 2));
                check(mm_n == {1'b0, cur_n}, "mm_n", mm_n, {1'b0, cur_n});
                ca = mm_a;
                cb = mm_b;
                cn = mm_n[255:0];
                stable = 1;
                pend = 1;
                cnt = $urandom_range(1, 0);
                starts_total++;
                last_st = cyc;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        static int base = 0;
        static bit prev_fin = 0;
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            base = starts_total;
            prev_fin = 0;
        end else begin
            if (prev_fin)
                check(!o_finished && !o_busy, "finish_one_cycle",
                      {255'd0, o_finished, o_busy}, 257'd0);
            if (o_finished) begin
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_finish", {1'b0, o_y}, 257'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(o_y == e.y, "o_y", {1'b0, o_y}, {1'b0, e.y});
                    check(starts_total - base == e.starts, "mm_start_count",
                          257'(starts_total - base), 257'(e.starts));
                    check(o_busy, "busy_at_finish", {256'd0, o_busy}, 257'd1);
                end
                base = starts_total;
            end
            prev_fin = o_finished;
        end
    end

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((o_busy || exp_q.size() != 0) && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        if (k >= BOUND) begin
            check(0, "timeout_idle", 257'(k), 257'(BOUND));
            finish_run();
        end
    endtask

    task automatic issue(input logic [255:0] x, input logic [255:0] d,
                         input logic [255:0] n);
        exp_t e;
        wait_idle();
        @(negedge clk);
        i_x = x;
        i_d = d;
        i_n = n;
        i_start = 1'b1;
        cur_n = n;
        e.y = modexp(x, d, n);
        e.starts = exp_starts(d);
        exp_q.push_back(e);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check(o_y == '0, {tag, "_o_y"}, {1'b0, o_y}, 257'd0);
        check(!o_finished && !o_busy && !mm_start, {tag, "_flags"},
              {254'd0, o_finished, o_busy, mm_start}, 257'd0);
        check(mm_a == '0 && mm_b == '0, {tag, "_mm_ab"}, {1'b0, mm_a | mm_b}, 257'd0);
        check(mm_n == '0, {tag, "_mm_n"}, mm_n, 257'd0);
    endtask

    initial begin
        logic [255:0] n;
        logic [255:0] x;
        int           k;
        int           cnt;
        bit           busy_ok;
        rst_n = 1'b0;
        i_start = 1'b0;
        i_x = '0;
        i_d = '0;
        i_n = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        issue(256'd5, 256'd3, 256'd13);
        issue(256'd7, 256'd0, 256'd11);
        issue(256'd0, 256'd5, 256'd11);

        for (int v = 0; v < 20; v++) begin
            n = rand256();
            n[255] = 1'b1;
            n[0] = 1'b1;
            x = rand256() % n;
            issue(x, rand256(), n);
        end

        // Re-pulsed start during pre-scale and during a multiplier wait
        n = rand256();
        n[255] = 1'b1;
        n[0] = 1'b1;
        issue(rand256() % n, rand256(), n);
        busy_ok = 1;
        repeat (100) begin
            @(negedge clk);
            busy_ok &= o_busy;
        end
        i_x = 256'd3;
        i_d = 256'd3;
        i_n = 256'd7;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        k = 0;
        while (!mm_start && k < BOUND) begin
            @(negedge clk);
            busy_ok &= o_busy;
            k++;
        end
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        while (!o_finished && k < BOUND) begin
            busy_ok &= o_busy;
            @(negedge clk);
            k++;
        end
        check(k < BOUND, "timeout_repulse", 257'(k), 257'(BOUND));
        check(busy_ok, "busy_continuous", {256'd0, busy_ok}, 257'd1);
        wait_idle();

        // Asynchronous reset while a squaring is outstanding
        issue(256'd3, 256'd7, 256'd1001);
        cnt = 0;
        k = 0;
        while (cnt < 2 && k < BOUND) begin
            @(negedge clk);
            k++;
            if (mm_start)
                cnt++;
        end
        check(cnt == 2, "reach_sqr_wait", 257'(cnt), 257'd2);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        issue(256'd2, 256'd10, 256'd1001);

`ifdef RSA_EARLY_EXIT_EN
        issue(256'd9, 256'd1, 256'd13);
`endif
        wait_idle();
        repeat (3) @(negedge clk);
        finish_run();
    end

endmodule

// File: doc/rsa_exp_ctrl.md
Name: rsa_exp_ctrl

Overview:
- Sequences one shared Montgomery multiplier (256-bit, radix-2) to compute o_y = i_x^i_d mod i_n for the RSA core.
- Runs a 256-cycle pre-scale, t = x*2^256 mod n, in internal shift-subtract logic.
- Then walks exponent bits LSB-first: multiply if the bit is 1, then square, every step issued to the external multiplier through a start/finished handshake.
- Sits between the top-level RSA wrapper (key/data load) and the multiplier instance.

Parameters:
KEY_BITS, 256, number of exponent bits processed (1..256); bits above KEY_BITS-1 ignored
PRE_BITS, 256, pre-scale shift count; must equal the multiplier's iteration count

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle request; sampled only in S_IDLE
i_x  in  256  base; precondition i_x < i_n
i_d  in  256  exponent
i_n  in  256  modulus; precondition odd, > 1
o_y  out  256  result; valid from o_finished pulse until next accepted i_start
o_finished  out  1  one-cycle done pulse
o_busy  out  1  high from accept cycle through the o_finished cycle
mm_start  out  1  one-cycle start to multiplier
mm_a  out  256  multiplier operand a; held stable from mm_start until mm_finished
mm_b  out  256  multiplier operand b; held stable from mm_start until mm_finished
mm_n  out  257  zero-extended i_n, latched at accept
mm_result  in  256  multiplier product, valid when mm_finished=1
mm_finished  in  1  multiplier done pulse

Behaviour:
- Reset (async, i_rst_n=0): state S_IDLE; o_y, o_finished, o_busy, mm_start, mm_a, mm_b, mm_n all 0; internal regs cleared.
- Reset mid-operation aborts immediately. Multiplier shares the reset; no drain.
- Accept: S_IDLE and i_start=1. Latch x, d, n. Set m=1, t=x, bit counter=0, pre counter=0. Next state S_PRE.
- i_start while busy is ignored; no queuing.
- S_PRE: once per cycle, t2 = {t,1'b0} (257 bits); t = (t2 >= n) ? t2-n : t2. Runs PRE_BITS cycles, then S_BIT.
- S_BIT: examine d_sh[0].
  - If 1: drive mm_a=m, mm_b=t, pulse mm_start; go S_MUL_WAIT.
  - Else: go S_SQR.
- S_MUL_WAIT: on mm_finished, m = mm_result; go S_GAP_M.
- S_GAP_M: one idle cycle; the multiplier needs one cycle after finished to return to idle. Then S_SQR.
- S_SQR: drive mm_a=t, mm_b=t, pulse mm_start; go S_SQR_WAIT.
- S_SQR_WAIT: on mm_finished, t = mm_result; d_sh >>= 1; bit counter+1; go S_GAP_S.
- S_GAP_S: one idle cycle.
  - If bit counter == KEY_BITS: go S_DONE.
  - Else: go S_BIT.
- S_DONE: o_y = m; o_finished=1 for exactly one cycle; o_busy drops the following cycle; return S_IDLE.
- mm_start is never asserted in two consecutive cycles, and never before the gap cycle after the previous mm_finished.
- mm_finished arriving in any non-WAIT state is ignored.
- Arithmetic: m stays in the normal domain, since MM(m, t*R) = m*t mod n. No final conversion multiply.
- Result is reduced (< n), given the multiplier's final conditional subtract.
- Edge cases:
  - d=0: no multiplies; y = 1.
  - x=0 with d≠0: y = 0.
- Latency: accept → S_PRE start = 1 cycle. Pre-scale = PRE_BITS cycles. Per bit = (mult latency + 2) × (1 + d bit) cycles. Done pulse = 1 cycle.

Optional Feature:
- Macro RSA_EARLY_EXIT_EN.
- Defined: in S_GAP_S, also go to S_DONE when the remaining d_sh == 0, skipping trailing squarings. Result is identical; cycle count is reduced.
- Undefined: always process exactly KEY_BITS bits, giving a data-independent squaring count.

Test Plan:
- x=5, d=3, n=13 → o_y=8; exactly 2 mul and KEY_BITS sqr mm_start pulses (undefined macro); o_finished high 1 cycle.
- x=7, d=0, n=11 → o_y=1; zero multiply starts. x=0, d=5, n=11 → o_y=0.
- Random 256-bit odd n (MSB set), x<n, d random, ≥20 vectors vs golden modexp model → exact match; mm_a/mm_b stable between mm_start and mm_finished.
- i_start re-pulsed during S_PRE and a WAIT state → ignored; o_y equals the first request's result; o_busy continuous.
- i_rst_n low for 1 cycle mid-S_SQR_WAIT → all outputs 0 asynchronously; a fresh start with x=2, d=10, n=1001 → o_y=23.
- RSA_EARLY_EXIT_EN defined, d=1, x=9, n=13 → o_y=9 after exactly 1 multiply and 1 square.
